// File: rtl/spu32_sram_arbiter.sv
// spu32_sram_arbiter: two-port tagged arbiter and pin sequencer for one 16-bit async SRAM
// Optional build macro SRAM_ARB_FIXED_PRIO_EN: port B wins simultaneous unlocked requests.
module spu32_sram_arbiter #(
    parameter int SRAM_ADDR_BITS = 18,
    parameter int WAIT_CYCLES    = 1
) (
    input  logic                      I_clk,
    input  logic                      I_reset_n,
    input  logic [3:0]                I_a_request,
    input  logic [SRAM_ADDR_BITS-1:0] I_a_addr,
    input  logic [15:0]               I_a_data,
    input  logic                      I_a_we,
    input  logic                      I_a_ub,
    input  logic                      I_a_lb,
    output logic [3:0]                O_a_ack,
    output logic                      O_a_stall,
    output logic [15:0]               O_a_data,
    input  logic [3:0]                I_b_request,
    input  logic [SRAM_ADDR_BITS-1:0] I_b_addr,
    input  logic [15:0]               I_b_data,
    input  logic                      I_b_we,
    input  logic                      I_b_ub,
    input  logic                      I_b_lb,
    output logic [3:0]                O_b_ack,
    output logic                      O_b_stall,
    output logic [15:0]               O_b_data,
    output logic [SRAM_ADDR_BITS-1:0] O_sram_addr,
    output logic [15:0]               O_sram_data,
    output logic                      O_sram_data_oe,
    input  logic [15:0]               I_sram_data,
    output logic                      O_sram_ce_n,
    output logic                      O_sram_oe_n,
    output logic                      O_sram_we_n,
    output logic                      O_sram_ub_n,
    output logic                      O_sram_lb_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    state_t                    state_q;
    logic [3:0]                cnt_q, tag_q, a_ack_q, b_ack_q;
    logic [SRAM_ADDR_BITS-1:0] addr_q;
    logic [15:0]               wdata_q, a_data_q, b_data_q;
    logic                      we_q, grant_b_q, lock_q, lock_b_q;
    logic                      ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, data_oe_q;
    logic                      a_req, b_req, lk, tie_b, sel_b, s_we, s_ub, s_lb;
    logic [3:0]                s_tag;
    logic [SRAM_ADDR_BITS-1:0] s_addr;
    logic [15:0]               s_data;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                      last_b_q;
`endif

    // Arbitration: a live lock forces its port; otherwise ties go to the tie-break winner
    always_comb begin
        a_req  = |I_a_request;
        b_req  = |I_b_request;
        lk     = lock_q && (lock_b_q ? b_req : a_req);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        tie_b  = 1'b1;
`else
        tie_b  = !last_b_q;
`endif
        sel_b  = lk ? lock_b_q : (a_req && b_req) ? tie_b : b_req;
        s_tag  = sel_b ? I_b_request : I_a_request;
        s_addr = sel_b ? I_b_addr : I_a_addr;
        s_data = sel_b ? I_b_data : I_a_data;
        s_we   = sel_b ? I_b_we : I_a_we;
        s_ub   = sel_b ? I_b_ub : I_a_ub;
        s_lb   = sel_b ? I_b_lb : I_a_lb;
    end

    // FSM with registered SRAM strobes, acks and read data
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            tag_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 16'd0;
            we_q      <= 1'b0;
            grant_b_q <= 1'b0;
            lock_q    <= 1'b0;
            lock_b_q  <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_b_q  <= 1'b1;
`endif
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            a_ack_q   <= 4'd0;
            b_ack_q   <= 4'd0;
            a_data_q  <= 16'd0;
            b_data_q  <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lock_q && !lk) lock_q <= 1'b0;
                    if (a_req || b_req) begin
                        grant_b_q <= sel_b;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                        last_b_q  <= sel_b;
`endif
                        if (s_tag[3]) begin
                            lock_q   <= 1'b1;
                            lock_b_q <= sel_b;
                        end
                        tag_q     <= s_tag;
                        addr_q    <= s_addr;
                        wdata_q   <= s_data;
                        we_q      <= s_we;
                        cnt_q     <= 4'(WAIT_CYCLES);
                        ce_n_q    <= 1'b0;
                        oe_n_q    <= s_we;
                        we_n_q    <= !s_we;
                        data_oe_q <= s_we;
                        ub_n_q    <= !s_ub;
                        lb_n_q    <= !s_lb;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        ce_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                        we_n_q    <= 1'b1;
                        ub_n_q    <= 1'b1;
                        lb_n_q    <= 1'b1;
                        data_oe_q <= 1'b0;
                        if (grant_b_q) b_ack_q <= tag_q;
                        else a_ack_q <= tag_q;
                        if (!we_q && grant_b_q) b_data_q <= I_sram_data;
                        if (!we_q && !grant_b_q) a_data_q <= I_sram_data;
                        if (!tag_q[3]) lock_q <= 1'b0;
                        state_q   <= ACK;
                    end else begin
                        we_n_q <= !(we_q && cnt_q != 4'd1);
                    end
                end
                ACK: begin
                    a_ack_q <= 4'd0;
                    b_ack_q <= 4'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign O_a_stall      = a_req && !(state_q == ACK && !grant_b_q);
    assign O_b_stall      = b_req && !(state_q == ACK && grant_b_q);
    assign O_a_ack        = a_ack_q;
    assign O_b_ack        = b_ack_q;
    assign O_a_data       = a_data_q;
    assign O_b_data       = b_data_q;
    assign O_sram_addr    = addr_q;
    assign O_sram_data    = wdata_q;
    assign O_sram_data_oe = data_oe_q;
    assign O_sram_ce_n    = ce_n_q;
    assign O_sram_oe_n    = oe_n_q;
    assign O_sram_we_n    = we_n_q;
    assign O_sram_ub_n    = ub_n_q;
    assign O_sram_lb_n    = lb_n_q;
endmodule
